qcw_ramp_sequencer: RTL
=======================

# qcw_ramp_sequencer

Burst sequencer sitting directly upstream of `qcw_driver`. Accepts burst requests, issues the one-cycle `start` pulse, and ramps the driver's `phase_shift` input linearly from a start value to an end value, one step per completed bridge cycle. Also supplies `cycle_limit`, enforces a minimum hold-off between bursts, and halts the driver on over-temperature, driver fault or loss of cycle feedback.

## Interface
- `PHASE_W`, 10: width of phase values (clk ticks).
- `CYCLE_W`, 10: width of cycle counts.
- `HOLD_W`, 24: width of the hold-off counter.
- `TIMEOUT`, 4800: max clk cycles between `cycle_finished` pulses in a burst (20 us at 240 MHz).

Ports:
- `clk` in 1: system clock (clk_240MHz domain).
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: gates acceptance of new bursts.
- `trigger` in 1: burst request, level-sampled in IDLE.
- `over_temp` in 1: asynchronous comparator input, active-high.
- `fault_clear` in 1: clears latched fault.
- `phase_start` in PHASE_W: initial phase shift.
- `phase_end` in PHASE_W: final phase shift.
- `phase_step` in PHASE_W: per-cycle increment magnitude.
- `cycle_count` in CYCLE_W: bridge cycles per burst.
- `holdoff` in HOLD_W: clk cycles of mandatory idle after a burst.
- `driver_ready` in 1: `qcw_driver` ready.
- `driver_cycle_finished` in 1: one-clk pulse per completed bridge cycle.
- `driver_fault` in 1: `qcw_driver` fault.
- `driver_start` out 1: one-clk start pulse.
- `driver_halt` out 1: halt request.
- `phase_shift` out PHASE_W: to driver.
- `cycle_limit` out CYCLE_W: to driver.
- `busy` out 1: high in any state except IDLE.
- `fault_latched` out 1: sticky fault flag.

## Operation
- `over_temp` passes through a 2-flop synchronizer (`ot_s`). All other inputs are synchronous to `clk`.
- States: IDLE, RAMP, HOLDOFF, FAULT.
- **IDLE**
  - `phase_shift` follows `phase_start`.
  - Accept a burst when `trigger & enable & driver_ready & ~ot_s & cycle_count!=0`.
  - On accept, shadow-latch `phase_start`/`phase_end`/`phase_step`/`cycle_count`, drive `cycle_limit` = latched count, pulse `driver_start`, clear the cycle counter and timeout counter, and go to RAMP.
  - A trigger with `cycle_count==0` is ignored.
- **RAMP**
  - On each `driver_cycle_finished`: increment the cycle counter, reset the timeout counter, and step the phase toward `phase_end`.
  - Phase step rule: if end >= start, phase = min(phase+step, end); otherwise phase = max(phase-step, end).
  - Phase arithmetic uses PHASE_W+1 bits and never wraps or overshoots. `phase_step==0` holds the phase constant.
  - When the counter reaches the latched count, go to HOLDOFF and load the hold-off counter with `holdoff`.
- **HOLDOFF**
  - Counter decrements each clk; at 0, go to IDLE.
  - Triggers are ignored, not queued.
  - `holdoff==0` returns to IDLE on the next clk.
- **FAULT entry**
  - Entered from RAMP on `ot_s`, `driver_fault`, or timeout counter reaching TIMEOUT.
  - Entered from any state on `driver_fault` or `ot_s`.
  - On entry, set `fault_latched`.
- **In FAULT**
  - `driver_halt` is held high.
  - `phase_shift` is forced to the latched `phase_start`.
  - Leave to IDLE only when `fault_clear & ~ot_s & ~driver_fault`. This clears `fault_latched` and drops `driver_halt`.
- **Priority, same cycle:** fault > cycle-count completion > phase step.
- Changes to config inputs during a burst have no effect until the next accept.

## Timing
- Reset values:
  - state IDLE; `driver_start` 0; `driver_halt` 1; `phase_shift` 0; `cycle_limit` 0; `busy` 0; `fault_latched` 0.
  - `driver_halt` drops on the first clk edge after reset deasserts.
- All outputs are registered.
- `driver_start` is high exactly one clk, on the cycle after the accepting sample. `busy` rises on the same cycle.
- `phase_shift` updates one clk after `driver_cycle_finished`.
- Over-temp to `driver_halt`: at most 3 clk (2 sync + 1 register).
- `driver_fault` to `driver_halt`: 1 clk.
- Timeout fault: `driver_halt` rises 1 clk after the timeout counter reaches TIMEOUT with no `cycle_finished`.
- Burst end: RAMP to HOLDOFF occurs 1 clk after the final `cycle_finished`.
- Next accept is possible no earlier than `holdoff`+1 clk after entering HOLDOFF.
- Asynchronous `reset` mid-burst immediately forces the reset values, including `driver_halt`=1.

## Test plan
- **Linear ramp:** start=300, end=100, step=2, count=50, 50 `cycle_finished` pulses 600 clk apart.
  - One `driver_start` pulse; `cycle_limit`=50.
  - `phase_shift` 298, 296, … 200.
  - `busy` drops `holdoff`+1 clk after the last pulse.
- **Saturation / upward ramp:** start=100, end=300, step=15, count=20.
  - `phase_shift` reaches exactly 300 after 14 pulses and holds.
  - No value exceeds 300; no wrap.
- **Over-temp mid-burst:** assert `over_temp` after the 10th `cycle_finished`.
  - `driver_halt` high within 3 clk; `fault_latched`=1.
  - Further triggers ignored.
  - `fault_clear` with `over_temp` low returns to IDLE and drops `driver_halt`.
- **Timeout:** TIMEOUT=4800; stop `cycle_finished` after 5 pulses.
  - `driver_halt` rises 1 clk after 4800 clk of no pulse.
  - `driver_start` never re-pulses.
- **Hold-off and gating:**
  - holdoff=1000; trigger held high continuously: next `driver_start` exactly 1002 clk after the final pulse of the previous burst.
  - With `enable`=0, `driver_ready`=0, or `cycle_count`=0: no `driver_start`.
- **Reset mid-burst:** assert `reset` during RAMP.
  - All outputs take reset values asynchronously.
  - After release, a new trigger produces a normal burst.

Source files
------------

// File: rtl/qcw_ramp_sequencer.sv
// qcw_ramp_sequencer
// Burst sequencer placed directly upstream of qcw_driver. It accepts burst
// requests, issues the one-cycle start pulse and ramps phase_shift linearly
// from a start value to an end value, one step per completed bridge cycle.
// It also supplies cycle_limit, enforces an idle hold-off between bursts and
// halts the driver on over-temperature, driver fault or loss of cycle feedback.
//
// Ports (clk_240MHz domain unless noted):
//   clk                   system clock
//   reset                 asynchronous, active-high
//   enable                gates acceptance of new bursts
//   trigger               burst request, level-sampled in IDLE
//   over_temp             asynchronous over-temperature comparator (synchronized here)
//   fault_clear           clears the latched fault
//   phase_start/_end/_step  ramp configuration (PHASE_W)
//   cycle_count           bridge cycles per burst (CYCLE_W)
//   holdoff               idle clk cycles forced after each burst (HOLD_W)
//   driver_ready          driver can take a new burst
//   driver_cycle_finished one-clk pulse per completed bridge cycle
//   driver_fault          driver fault indication
//   driver_start          one-clk start pulse to the driver
//   driver_halt           halt request to the driver
//   phase_shift           phase value to the driver (PHASE_W)
//   cycle_limit           latched cycle count to the driver (CYCLE_W)
//   busy                  high in every state except IDLE
//   fault_latched         sticky fault flag
module qcw_ramp_sequencer #(
    parameter int PHASE_W = 10,
    parameter int CYCLE_W = 10,
    parameter int HOLD_W  = 24,
    parameter int TIMEOUT = 4800
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               trigger,
    input  logic               over_temp,
    input  logic               fault_clear,
    input  logic [PHASE_W-1:0] phase_start,
    input  logic [PHASE_W-1:0] phase_end,
    input  logic [PHASE_W-1:0] phase_step,
    input  logic [CYCLE_W-1:0] cycle_count,
    input  logic [HOLD_W-1:0]  holdoff,
    input  logic               driver_ready,
    input  logic               driver_cycle_finished,
    input  logic               driver_fault,
    output logic               driver_start,
    output logic               driver_halt,
    output logic [PHASE_W-1:0] phase_shift,
    output logic [CYCLE_W-1:0] cycle_limit,
    output logic               busy,
    output logic               fault_latched
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]   TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_W-1:0] CYC_ONE   = {{(CYCLE_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAMP    = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t               state_r;
    logic                 ot_meta_r;
    logic                 ot_sync_r;
    logic [PHASE_W-1:0]   start_r;
    logic [PHASE_W-1:0]   end_r;
    logic [PHASE_W-1:0]   step_r;
    logic                 up_r;
    logic [CYCLE_W-1:0]   cycle_cnt_r;
    logic [TMO_W-1:0]     tmo_cnt_r;
    logic [HOLD_W-1:0]    hold_cnt_r;

    // One ramp step toward target, computed one bit wider so it can neither
    // wrap nor overshoot; a zero step leaves the phase unchanged.
    function automatic logic [PHASE_W-1:0] phase_step_f(
        input logic [PHASE_W-1:0] cur,
        input logic [PHASE_W-1:0] step,
        input logic [PHASE_W-1:0] target,
        input logic               up
    );
        logic [PHASE_W:0]   wide_v;
        logic [PHASE_W-1:0] res_v;
        if (up) begin
            wide_v = {1'b0, cur} + {1'b0, step};
            if (wide_v >= {1'b0, target}) res_v = target;
            else                          res_v = wide_v[PHASE_W-1:0];
        end else begin
            // Top bit set means the subtraction went below zero.
            wide_v = {1'b0, cur} - {1'b0, step};
            if (wide_v[PHASE_W] || (wide_v <= {1'b0, target})) res_v = target;
            else                                                res_v = wide_v[PHASE_W-1:0];
        end
        return res_v;
    endfunction

    logic               fault_req_s;
    logic               fault_entry_s;
    logic               accept_s;
    logic [CYCLE_W-1:0] cycle_cnt_inc_s;
    logic [PHASE_W-1:0] phase_next_s;

    assign fault_req_s     = driver_fault | ot_sync_r;
    // Timeout only counts against RAMP; the other sources apply everywhere.
    assign fault_entry_s   = (state_r != ST_FAULT) &&
                             (fault_req_s || ((state_r == ST_RAMP) && (tmo_cnt_r == TMO_LIMIT)));
    assign accept_s        = trigger & enable & driver_ready & ~ot_sync_r &
                             (cycle_count != {CYCLE_W{1'b0}});
    assign cycle_cnt_inc_s = cycle_cnt_r + CYC_ONE;
    assign phase_next_s    = phase_step_f(phase_shift, step_r, end_r, up_r);

    // Over-temp synchronizer, burst state machine and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            ot_meta_r     <= 1'b0;
            ot_sync_r     <= 1'b0;
            start_r       <= {PHASE_W{1'b0}};
            end_r         <= {PHASE_W{1'b0}};
            step_r        <= {PHASE_W{1'b0}};
            up_r          <= 1'b0;
            cycle_cnt_r   <= {CYCLE_W{1'b0}};
            tmo_cnt_r     <= {TMO_W{1'b0}};
            hold_cnt_r    <= {HOLD_W{1'b0}};
            driver_start  <= 1'b0;
            driver_halt   <= 1'b1;
            phase_shift   <= {PHASE_W{1'b0}};
            cycle_limit   <= {CYCLE_W{1'b0}};
            busy          <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            ot_meta_r    <= over_temp;
            ot_sync_r    <= ot_meta_r;
            driver_start <= 1'b0;
            if (fault_entry_s) begin
                state_r       <= ST_FAULT;
                fault_latched <= 1'b1;
                driver_halt   <= 1'b1;
                busy          <= 1'b1;
                phase_shift   <= start_r;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        driver_halt <= 1'b0;
                        phase_shift <= phase_start;
                        if (accept_s) begin
                            start_r      <= phase_start;
                            end_r        <= phase_end;
                            step_r       <= phase_step;
                            up_r         <= (phase_end >= phase_start);
                            cycle_limit  <= cycle_count;
                            cycle_cnt_r  <= {CYCLE_W{1'b0}};
                            tmo_cnt_r    <= {TMO_W{1'b0}};
                            driver_start <= 1'b1;
                            busy         <= 1'b1;
                            state_r      <= ST_RAMP;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    ST_RAMP: begin
                        if (driver_cycle_finished) begin
                            // The final cycle still steps the phase, then ends the burst.
                            cycle_cnt_r <= cycle_cnt_inc_s;
                            tmo_cnt_r   <= {TMO_W{1'b0}};
                            phase_shift <= phase_next_s;
                            if (cycle_cnt_inc_s == cycle_limit) begin
                                hold_cnt_r <= holdoff;
                                state_r    <= ST_HOLDOFF;
                            end else begin
                                state_r <= ST_RAMP;
                            end
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                        end
                    end
                    ST_FAULT: begin
                        driver_halt <= 1'b1;
                        phase_shift <= start_r;
                        if (fault_clear && !fault_req_s) begin
                            state_r       <= ST_IDLE;
                            fault_latched <= 1'b0;
                            driver_halt   <= 1'b0;
                            busy          <= 1'b0;
                        end else begin
                            state_r <= ST_FAULT;
                        end
                    end
                    default: begin
                        state_r       <= ST_FAULT;
                        fault_latched <= 1'b1;
                        driver_halt   <= 1'b1;
                        busy          <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
